// File: rtl/utoss_mem_bridge.sv
// Turns one core memory request into a framed BUS_W-bit serial pin transaction; registered outputs, CMD beat 1 cycle after accept.
// One transaction in flight (req_ready only in IDLE); defining UTOSS_BRIDGE_TIMEOUT_EN adds a WAIT timeout reported on rsp_err.
module utoss_mem_bridge #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int BUS_W   = 4,
    parameter int TIMEOUT = 255
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_we,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic [DATA_W-1:0]   req_wdata,
    input  logic [DATA_W/8-1:0] req_wstrb,
    output logic                rsp_valid,
    output logic [DATA_W-1:0]   rsp_rdata,
    output logic                rsp_err,
    output logic                pin_frame,
    output logic [BUS_W-1:0]    pin_out,
    output logic [BUS_W-1:0]    pin_oe,
    input  logic [BUS_W-1:0]    pin_in,
    input  logic                pin_ack
);
    localparam int STRB_W     = DATA_W / 8;
    localparam int STRB_BEATS = (STRB_W + BUS_W - 1) / BUS_W;
    localparam int STRB_PAD   = STRB_BEATS * BUS_W;
    localparam int ADDR_BEATS = ADDR_W / BUS_W;
    localparam int DATA_BEATS = DATA_W / BUS_W;
    localparam int MAX_AS     = (ADDR_BEATS > STRB_BEATS) ? ADDR_BEATS : STRB_BEATS;
    localparam int MAX_BEATS  = (MAX_AS > DATA_BEATS) ? MAX_AS : DATA_BEATS;
    localparam int CNT_W      = (MAX_BEATS > 1) ? $clog2(MAX_BEATS) : 1;

    localparam logic [CNT_W-1:0] STRB_LAST = CNT_W'(STRB_BEATS - 1);
    localparam logic [CNT_W-1:0] ADDR_LAST = CNT_W'(ADDR_BEATS - 1);
    localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_BEATS - 1);
    localparam logic [CNT_W-1:0] RD_LAST   = CNT_W'((DATA_BEATS > 1) ? DATA_BEATS - 2 : 0);

    typedef enum logic [3:0] {
        S_IDLE, S_CMD, S_STRB, S_ADDR, S_WDATA, S_TURN, S_WAIT, S_RDATA, S_RESP
    } state_t;

    state_t              r_state;
    logic                r_ready;
    logic                r_we;
    logic                r_rsp_valid;
    logic                r_frame;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_wdata;
    logic [STRB_PAD-1:0] r_strb;
    logic [DATA_W-1:0]   r_rd_sh;
    logic [DATA_W-1:0]   r_rdata;
    logic [CNT_W-1:0]    r_cnt;
    logic [BUS_W-1:0]    r_pin_out;
    logic [BUS_W-1:0]    r_pin_oe;
    logic [CNT_W-1:0]    w_idx;
    logic [DATA_W-1:0]   w_rd_next;
    logic                w_timeout;

    // Beat 0 lands in WAIT; RDATA beat k (counter k-1) fills slot k.
    always_comb begin
        w_idx     = (r_state == S_WAIT) ? '0 : r_cnt + 1'b1;
        w_rd_next = r_rd_sh;
        w_rd_next[w_idx*BUS_W +: BUS_W] = pin_in;
    end

`ifdef UTOSS_BRIDGE_TIMEOUT_EN
    localparam int TO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

    logic [TO_W-1:0] r_to_cnt;
    logic            r_rsp_err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_to_cnt  <= '0;
            r_rsp_err <= 1'b0;
        end else begin
            r_to_cnt <= (r_state == S_WAIT) ? r_to_cnt + 1'b1 : '0;
            if (r_state == S_WAIT && (pin_ack || w_timeout))
                r_rsp_err <= !pin_ack;
        end
    end

    assign w_timeout = (r_state == S_WAIT) && (r_to_cnt == TO_LAST);
    assign rsp_err   = r_rsp_err;
`else
    assign w_timeout = 1'b0;
    assign rsp_err   = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_ready     <= 1'b0;
            r_we        <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_frame     <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_strb      <= '0;
            r_rd_sh     <= '0;
            r_rdata     <= '0;
            r_cnt       <= '0;
            r_pin_out   <= '0;
            r_pin_oe    <= '0;
        end else begin
            r_rsp_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (req_valid && r_ready) begin
                        r_ready   <= 1'b0;
                        r_we      <= req_we;
                        r_addr    <= req_addr;
                        r_wdata   <= req_wdata;
                        r_strb    <= STRB_PAD'(req_wstrb);
                        r_frame   <= 1'b1;
                        r_pin_oe  <= '1;
                        r_pin_out <= BUS_W'(req_we) << (BUS_W - 1);
                        r_cnt     <= '0;
                        r_state   <= S_CMD;
                    end else begin
                        r_ready <= 1'b1;
                    end
                end
                S_CMD: begin
                    r_cnt <= '0;
                    if (r_we) begin
                        r_pin_out <= r_strb[BUS_W-1:0];
                        r_strb    <= r_strb >> BUS_W;
                        r_state   <= S_STRB;
                    end else begin
                        r_pin_out <= r_addr[BUS_W-1:0];
                        r_addr    <= r_addr >> BUS_W;
                        r_state   <= S_ADDR;
                    end
                end
                S_STRB: begin
                    if (r_cnt == STRB_LAST) begin
                        r_cnt     <= '0;
                        r_pin_out <= r_addr[BUS_W-1:0];
                        r_addr    <= r_addr >> BUS_W;
                        r_state   <= S_ADDR;
                    end else begin
                        r_cnt     <= r_cnt + 1'b1;
                        r_pin_out <= r_strb[BUS_W-1:0];
                        r_strb    <= r_strb >> BUS_W;
                    end
                end
                S_ADDR: begin
                    if (r_cnt == ADDR_LAST) begin
                        r_cnt <= '0;
                        if (r_we) begin
                            r_pin_out <= r_wdata[BUS_W-1:0];
                            r_wdata   <= r_wdata >> BUS_W;
                            r_state   <= S_WDATA;
                        end else begin
                            r_pin_out <= '0;
                            r_pin_oe  <= '0;
                            r_state   <= S_TURN;
                        end
                    end else begin
                        r_cnt     <= r_cnt + 1'b1;
                        r_pin_out <= r_addr[BUS_W-1:0];
                        r_addr    <= r_addr >> BUS_W;
                    end
                end
                S_WDATA: begin
                    if (r_cnt == DATA_LAST) begin
                        r_cnt     <= '0;
                        r_pin_out <= '0;
                        r_pin_oe  <= '0;
                        r_state   <= S_WAIT;
                    end else begin
                        r_cnt     <= r_cnt + 1'b1;
                        r_pin_out <= r_wdata[BUS_W-1:0];
                        r_wdata   <= r_wdata >> BUS_W;
                    end
                end
                S_TURN: begin
                    r_cnt   <= '0;
                    r_state <= S_WAIT;
                end
                S_WAIT: begin
                    r_cnt <= '0;
                    if (pin_ack) begin
                        if (r_we) begin
                            r_frame     <= 1'b0;
                            r_rsp_valid <= 1'b1;
                            r_state     <= S_RESP;
                        end else begin
                            r_rd_sh <= w_rd_next;
                            if (DATA_BEATS == 1) begin
                                r_rdata     <= w_rd_next;
                                r_frame     <= 1'b0;
                                r_rsp_valid <= 1'b1;
                                r_state     <= S_RESP;
                            end else begin
                                r_state <= S_RDATA;
                            end
                        end
                    end else if (w_timeout) begin
                        r_frame     <= 1'b0;
                        r_rsp_valid <= 1'b1;
                        r_state     <= S_RESP;
                    end
                end
                S_RDATA: begin
                    r_rd_sh <= w_rd_next;
                    if (r_cnt == RD_LAST) begin
                        r_cnt       <= '0;
                        r_rdata     <= w_rd_next;
                        r_frame     <= 1'b0;
                        r_rsp_valid <= 1'b1;
                        r_state     <= S_RESP;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_RESP: begin
                    r_ready <= 1'b1;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign req_ready = r_ready;
    assign rsp_valid = r_rsp_valid;
    assign rsp_rdata = r_rdata;
    assign pin_frame = r_frame;
    assign pin_out   = r_pin_out;
    assign pin_oe    = r_pin_oe;
endmodule

// File: tb/tb_utoss_mem_bridge.sv
// Bench for utoss_mem_bridge: directed and random frames checked cycle by cycle against a frame-level expectation list.
`timescale 1ns/1ps
module tb_utoss_mem_bridge;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int BW = 4;
    localparam int TO = 4;
    localparam int SB = ((DW / 8) + BW - 1) / BW;
    localparam int AB = AW / BW;
    localparam int DB = DW / BW;
`ifdef UTOSS_BRIDGE_TIMEOUT_EN
    localparam int MAXW = TO;
`else
    localparam int MAXW = 6;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic          req_valid, req_ready, req_we;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_wdata;
    logic [DW/8-1:0] req_wstrb;
    logic          rsp_valid, rsp_err;
    logic [DW-1:0] rsp_rdata;
    logic          pin_frame, pin_ack;
    logic [BW-1:0] pin_out, pin_oe, pin_in;

    logic        e8_req_valid, e8_req_ready, e8_req_we;
    logic [15:0] e8_req_addr;
    logic [31:0] e8_req_wdata;
    logic [3:0]  e8_req_wstrb;
    logic        e8_rsp_valid, e8_rsp_err;
    logic [31:0] e8_rsp_rdata;
    logic        e8_pin_frame, e8_pin_ack;
    logic [7:0]  e8_pin_out, e8_pin_oe, e8_pin_in;

    utoss_mem_bridge #(.ADDR_W(AW), .DATA_W(DW), .BUS_W(BW), .TIMEOUT(TO)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .pin_frame(pin_frame), .pin_out(pin_out), .pin_oe(pin_oe),
        .pin_in(pin_in), .pin_ack(pin_ack)
    );

    utoss_mem_bridge #(.ADDR_W(16), .DATA_W(32), .BUS_W(8), .TIMEOUT(TO)) u_dut8 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(e8_req_valid), .req_ready(e8_req_ready), .req_we(e8_req_we),
        .req_addr(e8_req_addr), .req_wdata(e8_req_wdata), .req_wstrb(e8_req_wstrb),
        .rsp_valid(e8_rsp_valid), .rsp_rdata(e8_rsp_rdata), .rsp_err(e8_rsp_err),
        .pin_frame(e8_pin_frame), .pin_out(e8_pin_out), .pin_oe(e8_pin_oe),
        .pin_in(e8_pin_in), .pin_ack(e8_pin_ack)
    );

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic          frame;
        logic [BW-1:0] oe;
        logic [BW-1:0] out;
        logic          vld;
        logic          rdy;
    } row_t;

    row_t          rows[$];
    logic [DW-1:0] model_rdata = '0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic row_t mk(input logic f, input logic [BW-1:0] oe, input logic [BW-1:0] o,
                                input logic v, input logic r);
        row_t t;
        t.frame = f; t.oe = oe; t.out = o; t.vld = v; t.rdy = r;
        return t;
    endfunction

    function automatic logic [63:0] obs_pins();
        row_t t;
        t = mk(pin_frame, pin_oe, pin_out, rsp_valid, req_ready);
        return 64'(t);
    endfunction

    // Builds the expected pin/handshake trace of one frame from the protocol rules, then plays the device side.
    task automatic do_txn(input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                          input logic [DW/8-1:0] wstrb, input int wait_len, input bit no_ack,
                          input bit keep_valid, input logic [DW-1:0] rd_word);
        logic [BW-1:0] cmd;
        logic [DW-1:0] exp_rd;
        logic          exp_err;
        int            ack_cycle, n;
        bit            in_rd;
        rows.delete();
        cmd = '0;
        cmd[BW-1] = we;
        rows.push_back(mk(1'b1, '1, cmd, 1'b0, 1'b0));
        if (we)
            for (int i = 0; i < SB; i++) rows.push_back(mk(1'b1, '1, BW'(wstrb >> (BW * i)), 1'b0, 1'b0));
        for (int i = 0; i < AB; i++) rows.push_back(mk(1'b1, '1, BW'(addr >> (BW * i)), 1'b0, 1'b0));
        if (we)
            for (int i = 0; i < DB; i++) rows.push_back(mk(1'b1, '1, BW'(wdata >> (BW * i)), 1'b0, 1'b0));
        else
            rows.push_back(mk(1'b1, '0, '0, 1'b0, 1'b0));
        ack_cycle = no_ack ? -1 : rows.size() + wait_len;
        for (int i = 0; i < wait_len; i++) rows.push_back(mk(1'b1, '0, '0, 1'b0, 1'b0));
        if (!we && !no_ack)
            for (int i = 1; i < DB; i++) rows.push_back(mk(1'b1, '0, '0, 1'b0, 1'b0));
        rows.push_back(mk(1'b0, '0, '0, 1'b1, 1'b0));
        rows.push_back(mk(1'b0, '0, '0, 1'b0, 1'b1));
        exp_err     = no_ack;
        exp_rd      = (!we && !no_ack) ? rd_word : model_rdata;
        model_rdata = exp_rd;

        req_we = we; req_addr = addr; req_wdata = wdata; req_wstrb = wstrb; req_valid = 1'b1;
        n = 0;
        while (req_ready !== 1'b1 && n < 40) begin
            step();
            n++;
        end
        chk("accept_wait", 64'(n < 40), 64'(1));
        step();
        req_valid = keep_valid;
        req_we = 1'($urandom); req_addr = AW'($urandom); req_wdata = DW'($urandom); req_wstrb = 4'($urandom);

        for (int c = 1; c <= rows.size(); c++) begin
            in_rd   = !we && !no_ack && c >= ack_cycle && c < ack_cycle + DB;
            pin_ack = (c == ack_cycle) ? 1'b1 : (in_rd && c != ack_cycle ? 1'($urandom) : 1'b0);
            pin_in  = in_rd ? rd_word[BW*(c-ack_cycle) +: BW] : BW'($urandom);
            chk($sformatf("pins_c%0d", c), obs_pins(), 64'(rows[c-1]));
            if (rows[c-1].vld) begin
                chk("rsp_rdata", 64'(rsp_rdata), 64'(exp_rd));
                chk("rsp_err", 64'(rsp_err), 64'(exp_err));
            end
            if (c < rows.size()) step();
        end
        pin_ack = 1'b0;
    endtask

    int            n;
    logic [AW-1:0] ab_addr;
    logic [15:0]   a8;
    logic [31:0]   w8;
    logic [7:0]    e8_frame_oe_out [3];

    initial begin
        req_valid = 0; req_we = 0; req_addr = '0; req_wdata = '0; req_wstrb = '0;
        pin_in = '0; pin_ack = 0;
        e8_req_valid = 0; e8_req_we = 0; e8_req_addr = '0; e8_req_wdata = '0; e8_req_wstrb = '0;
        e8_pin_in = '0; e8_pin_ack = 0;

        #12;
        chk("rst_pins", obs_pins(), 64'(0));
        chk("rst_rsp", {30'd0, rsp_err, rsp_valid, rsp_rdata}, 64'(0));
        chk("rst_b8", {e8_pin_frame, e8_pin_oe, e8_pin_out, e8_rsp_valid, e8_req_ready, e8_rsp_err}, 64'(0));
        rst_n = 1'b1;
        #1 chk("ready_before_edge", 64'(req_ready), 64'(0));
        step();
        chk("ready_after_edge", 64'(req_ready), 64'(1));

        do_txn(1'b0, 32'h0000_1234, '0, '0, 1, 1'b0, 1'b0, 32'h89AB_CDEF);
        chk("rd_directed", 64'(rsp_rdata), 64'h89AB_CDEF);
        do_txn(1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 4'h5, 3, 1'b0, 1'b0, '0);
        chk("wr_keeps_rdata", 64'(rsp_rdata), 64'h89AB_CDEF);

        do_txn(1'b0, $urandom, '0, '0, 1 + 32'($urandom_range(0, MAXW - 1)), 1'b0, 1'b1, $urandom);
        do_txn(1'b0, $urandom, '0, '0, 1 + 32'($urandom_range(0, MAXW - 1)), 1'b0, 1'b0, $urandom);

`ifdef UTOSS_BRIDGE_TIMEOUT_EN
        do_txn(1'b0, $urandom, '0, '0, TO, 1'b1, 1'b0, $urandom);
`endif

        // Abort a read in the middle of its ADDR phase.
        ab_addr = $urandom;
        req_we = 0; req_addr = ab_addr; req_valid = 1;
        n = 0;
        while (req_ready !== 1'b1 && n < 40) begin step(); n++; end
        chk("abort_accept", 64'(n < 40), 64'(1));
        step();
        req_valid = 0;
        repeat (4) step();
        chk("abort_addr3", {55'd0, pin_frame, pin_oe, pin_out}, {55'd0, 1'b1, 4'hF, ab_addr[15:12]});
        rst_n = 1'b0;
        #1;
        chk("abort_pins", obs_pins(), 64'(0));
        chk("abort_rsp", {30'd0, rsp_err, rsp_valid, rsp_rdata}, 64'(0));
        repeat (3) begin
            step();
            chk("abort_hold", obs_pins(), 64'(0));
        end
        #3 rst_n = 1'b1;
        #1 chk("abort_ready_low", 64'(req_ready), 64'(0));
        model_rdata = '0;
        step();
        chk("abort_ready_up", 64'(req_ready), 64'(1));
        do_txn(1'b0, $urandom, '0, '0, 1, 1'b0, 1'b0, $urandom);

        for (int i = 0; i < 10; i++)
            do_txn(1'($urandom), $urandom, $urandom, 4'($urandom),
                   1 + 32'($urandom_range(0, MAXW - 1)), 1'b0, (i < 9) ? 1'($urandom) : 1'b0, $urandom);

        // 8-bit bus, 16-bit address read: 1 CMD, 2 ADDR, TURN, WAIT, 3 RDATA, RESP, IDLE.
        a8 = 16'($urandom);
        w8 = $urandom;
        e8_req_we = 0; e8_req_addr = a8; e8_req_valid = 1;
        n = 0;
        while (e8_req_ready !== 1'b1 && n < 40) begin step(); n++; end
        chk("b8_accept", 64'(n < 40), 64'(1));
        step();
        e8_req_valid = 0;
        e8_req_addr  = 16'($urandom);
        e8_frame_oe_out[0] = 8'h00;
        e8_frame_oe_out[1] = a8[7:0];
        e8_frame_oe_out[2] = a8[15:8];
        for (int c = 1; c <= 10; c++) begin
            e8_pin_ack = (c == 5);
            e8_pin_in  = (c >= 5 && c <= 8) ? w8[8*(c-5) +: 8] : 8'($urandom);
            chk($sformatf("b8_pins_c%0d", c),
                {45'd0, e8_pin_frame, e8_pin_oe, e8_pin_out, e8_rsp_valid, e8_req_ready},
                {45'd0, c <= 8, (c <= 3) ? 8'hFF : 8'h00, (c <= 3) ? e8_frame_oe_out[c-1] : 8'h00,
                 c == 9, c == 10});
            if (c == 9) chk("b8_rdata", 64'(e8_rsp_rdata), 64'(w8));
            if (c < 10) step();
        end
        e8_pin_ack = 0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
